// File: rtl/ksa32_top.sv
// rtl/ksa32_top.sv - 32-bit Kogge-Stone adder with registered sum, carry-out and overflow
// Prefix tree is built from explicit black/gray cells; the last level needs no group propagate.

module ksa_black_cell (
  input  logic g_hi_i,
  input  logic p_hi_i,
  input  logic g_lo_i,
  input  logic p_lo_i,
  output logic g_o,
  output logic p_o
);
  assign g_o = g_hi_i | (p_hi_i & g_lo_i);
  assign p_o = p_hi_i & p_lo_i;
endmodule

module ksa_gray_cell (
  input  logic g_hi_i,
  input  logic p_hi_i,
  input  logic g_lo_i,
  output logic g_o
);
  assign g_o = g_hi_i | (p_hi_i & g_lo_i);
endmodule

module ksa32_top (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] SUM,
  output logic        COUT,
  output logic        overflow
);
  logic [31:0] g_pre;
  logic [31:0] p_pre;
  logic [31:0] g_lvl [0:5];
  logic [31:0] p_lvl [0:4];
  logic [31:0] carry;
  logic [31:0] sum_d, sum_q;
  logic        cout_d, cout_q;
  logic        ovf_d, ovf_q;
  logic        unused_p;

  assign g_pre    = A & B;
  assign p_pre    = A ^ B;
  assign g_lvl[0] = g_pre;
  assign p_lvl[0] = p_pre;

  // Level lv combines each bit with the bit 2**lv below it.
  genvar lv, i;
  generate
    for (lv = 0; lv < 5; lv++) begin : g_level
      for (i = 0; i < 32; i++) begin : g_bit
        if (i < (1 << lv)) begin : g_pass
          assign g_lvl[lv+1][i] = g_lvl[lv][i];
          if (lv < 4) begin : g_ppass
            assign p_lvl[lv+1][i] = p_lvl[lv][i];
          end
        end else if (lv == 4) begin : g_gray
          ksa_gray_cell u_cell (
            .g_hi_i (g_lvl[lv][i]),
            .p_hi_i (p_lvl[lv][i]),
            .g_lo_i (g_lvl[lv][i-(1<<lv)]),
            .g_o    (g_lvl[lv+1][i])
          );
        end else begin : g_black
          ksa_black_cell u_cell (
            .g_hi_i (g_lvl[lv][i]),
            .p_hi_i (p_lvl[lv][i]),
            .g_lo_i (g_lvl[lv][i-(1<<lv)]),
            .p_lo_i (p_lvl[lv][i-(1<<lv)]),
            .g_o    (g_lvl[lv+1][i]),
            .p_o    (p_lvl[lv+1][i])
          );
        end
      end
    end
  endgenerate

  // Lower half of the last propagate level only feeds the final gray cells' low side, which ignores it.
  assign unused_p = ^p_lvl[4][15:0];

  assign carry  = {g_lvl[5][30:0], 1'b0};
  assign sum_d  = p_pre ^ carry;
  assign cout_d = g_lvl[5][31];
  assign ovf_d  = carry[31] ^ cout_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q  <= 32'h0000_0000;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign SUM      = sum_q;
  assign COUT     = cout_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_ksa32_top.sv
// tb/tb_ksa32_top.sv - scoreboard bench for ksa32_top against an arithmetic reference model
// Stimulus pushes expected results; an independent monitor pops and compares each cycle.

module tb_ksa32_top;
  logic        clk;
  logic        rst;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] SUM;
  logic        COUT;
  logic        overflow;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [33:0] res;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  bit   mon_en = 0;

  ksa32_top dut (
    .clk      (clk),
    .rst      (rst),
    .A        (A),
    .B        (B),
    .SUM      (SUM),
    .COUT     (COUT),
    .overflow (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    logic        ovf;
    s   = {1'b0, a} + {1'b0, b};
    ovf = (a[31] == b[31]) && (s[31] != a[31]);
    return {s[31:0], s[32], ovf};
  endfunction

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got SUM=%h COUT=%b overflow=%b, required SUM=%h COUT=%b overflow=%b",
               name, act[33:2], act[1], act[0], exp[33:2], exp[1], exp[0]);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    @(negedge clk);
    A = a;
    B = b;
    e.a = a;
    e.b = b;
    e.res = model(a, b);
    sb.push_back(e);
  endtask

  // Monitor: one result per cycle, checked just after the edge and again after inputs move.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && !rst) begin
        if (sb.size() == 0) begin
          check("scoreboard_underflow", {SUM, COUT, overflow}, 34'h3_FFFF_FFFF ^ {SUM, COUT, overflow});
        end else begin
          e = sb.pop_front();
          check($sformatf("result a=%h(%0d) b=%h(%0d)", e.a, e.a, e.b, e.b), {SUM, COUT, overflow}, e.res);
          @(negedge clk);
          #1;
          check("hold_between_edges", {SUM, COUT, overflow}, e.res);
        end
      end
    end
  end

  initial begin
    logic [31:0] ra, rb;
    logic [31:0] corners [5];
    exp_t e;
    corners[0] = 32'h0000_0000;
    corners[1] = 32'h0000_0001;
    corners[2] = 32'h7FFF_FFFF;
    corners[3] = 32'h8000_0000;
    corners[4] = 32'hFFFF_FFFF;

    rst = 1'b0;
    A   = 32'hFFFF_FFFF;
    B   = 32'h0000_0001;
    #1 rst = 1'b1;
    #1 check("reset_async_before_edge", {SUM, COUT, overflow}, 34'h0);
    repeat (2) @(posedge clk);
    #1 check("reset_held", {SUM, COUT, overflow}, 34'h0);

    @(negedge clk);
    rst = 1'b0;
    e.a = A;
    e.b = B;
    e.res = {32'h0, 1'b1, 1'b0};
    sb.push_back(e);
    mon_en = 1'b1;

    drive(32'd5, 32'd7);
    drive(32'hFFFF_FFFF, 32'h0000_0001);
    drive(32'h7FFF_FFFF, 32'h0000_0000);
    drive(32'h7FFF_FFFF, 32'h0000_0001);
    drive(32'h8000_0000, 32'h8000_0000);
    drive(32'hAAAA_AAAA, 32'h5555_5555);
    drive(32'h5555_5555, 32'h5555_5555);

    for (int n = 0; n < 10000; n++) begin
      case ($urandom_range(0, 3))
        0: begin ra = $urandom; rb = $urandom; end
        1: begin ra = $urandom; rb = ~ra + 32'd1; end
        2: begin ra = corners[$urandom_range(0, 4)]; rb = $urandom; end
        default: begin ra = corners[$urandom_range(0, 4)]; rb = corners[$urandom_range(0, 4)]; end
      endcase
      drive(ra, rb);
    end

    @(negedge clk);
    #2;
    mon_en = 1'b0;
    A = 32'h8000_0000;
    B = 32'h8000_0001;
    @(posedge clk);
    #1 check("pre_reset_result", {SUM, COUT, overflow}, model(32'h8000_0000, 32'h8000_0001));
    #2 rst = 1'b1;
    #1 check("reset_mid_stream", {SUM, COUT, overflow}, 34'h0);
    @(posedge clk);
    #1 check("reset_mid_stream_held", {SUM, COUT, overflow}, 34'h0);

    @(negedge clk);
    rst = 1'b0;
    A = 32'h0000_FFFF;
    B = 32'h0000_0001;
    e.a = A;
    e.b = B;
    e.res = model(A, B);
    sb.push_back(e);
    mon_en = 1'b1;
    for (int n = 0; n < 50; n++) drive($urandom, $urandom);

    @(negedge clk);
    #2;
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
